// File: rtl/wb_shared_bus_if.sv
// Signal bundle for the two-master / NSLV-slave Wishbone B4 classic shared bus.
// The interconnect takes the "bus" modport; masters and slaves use their own views.
interface wb_shared_bus_if #(
    parameter int AW   = 32,
    parameter int DW   = 32,
    parameter int NSLV = 3
);
    logic [1:0]                 m_cyc;
    logic [1:0]                 m_stb;
    logic [1:0]                 m_we;
    logic [1:0][AW-1:0]         m_adr;
    logic [1:0][DW-1:0]         m_dat_w;
    logic [1:0][DW/8-1:0]       m_sel;
    logic [1:0][DW-1:0]         m_dat_r;
    logic [1:0]                 m_ack;
    logic [1:0]                 m_err;

    logic [NSLV-1:0]            s_cyc;
    logic [NSLV-1:0]            s_stb;
    logic                       s_we;
    logic [AW-1:0]              s_adr;
    logic [DW-1:0]              s_dat_w;
    logic [DW/8-1:0]            s_sel;
    logic [NSLV-1:0][DW-1:0]    s_dat_r;
    logic [NSLV-1:0]            s_ack;

    logic [1:0]                 gnt;

    modport master (
        output m_cyc, m_stb, m_we, m_adr, m_dat_w, m_sel,
        input  m_dat_r, m_ack, m_err, gnt
    );

    modport slave (
        input  s_cyc, s_stb, s_we, s_adr, s_dat_w, s_sel,
        output s_dat_r, s_ack
    );

    modport bus (
        input  m_cyc, m_stb, m_we, m_adr, m_dat_w, m_sel, s_dat_r, s_ack,
        output m_dat_r, m_ack, m_err,
        output s_cyc, s_stb, s_we, s_adr, s_dat_w, s_sel, gnt
    );
endinterface

// File: rtl/wb_shared_bus.sv
// Shared-bus Wishbone B4 classic interconnect: two masters (I/D bus) onto bootRom, RAM and LED.
// Round-robin-by-last arbitration, mask/base decode, unmapped and hung accesses become bus errors.
//
//  state  | meaning
//  -------+---------------------------------------------------------------
//  S_IDLE | no owner; any m_cyc grants next edge, tie goes to master != last
//  S_GNT0 | master 0 (I bus) owns the bus until it drops m_cyc
//  S_GNT1 | master 1 (D bus) owns the bus until it drops m_cyc
module wb_shared_bus #(
    parameter int AW   = 32,
    parameter int DW   = 32,
    parameter int NSLV = 3,
    parameter logic [NSLV-1:0][AW-1:0] SLV_BASE = {32'h8000_0000, 32'h1000_0000, 32'h0000_0000},
    parameter logic [NSLV-1:0][AW-1:0] SLV_MASK = {32'hFFFF_FFF0, 32'hFFFF_0000, 32'hFFFF_F000},
    parameter int TIMEOUT = 255
) (
    input  logic            i_clock,
    input  logic            i_reset_n,
    wb_shared_bus_if.bus    io_bus
);
    localparam int          IW     = (NSLV > 1) ? $clog2(NSLV) : 1;
    localparam logic [7:0]  LP_TO  = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GNT0 = 2'd1,
        S_GNT1 = 2'd2
    } state_t;

    state_t         r_state;
    logic           r_last;
    logic [1:0]     r_gnt;
    logic [7:0]     r_cnt;
    logic           r_err_q;

    logic           w_granted;
    logic           w_own;
    logic [AW-1:0]  w_adr;
    logic [IW-1:0]  w_hit;
    logic           w_any_hit;
    logic           w_cyc;
    logic           w_stb;
    logic           w_sack;
    logic           w_ack;
    logic           w_stall;

    always_comb begin
        w_granted = (r_state == S_GNT0) || (r_state == S_GNT1);
        w_own     = (r_state == S_GNT1);
        w_adr     = io_bus.m_adr[w_own];
        w_cyc     = w_granted & io_bus.m_cyc[w_own];
        w_stb     = w_cyc & io_bus.m_stb[w_own];
    end

    // Scan from the top so the lowest-indexed overlapping window is the one that sticks.
    always_comb begin
        w_hit     = '0;
        w_any_hit = 1'b0;
        for (int i = NSLV - 1; i >= 0; i--) begin
            if ((w_adr & SLV_MASK[i]) == SLV_BASE[i]) begin
                w_hit     = i[IW-1:0];
                w_any_hit = 1'b1;
            end
        end
    end

    always_comb begin
        w_sack  = w_any_hit & io_bus.s_ack[w_hit];
        w_ack   = w_stb & w_sack & ~r_err_q;
        w_stall = w_stb & w_any_hit & ~w_sack & ~r_err_q;
    end

    always_comb begin
        io_bus.s_cyc   = '0;
        io_bus.s_stb   = '0;
        io_bus.s_we    = 1'b0;
        io_bus.s_adr   = '0;
        io_bus.s_dat_w = '0;
        io_bus.s_sel   = '0;
        io_bus.m_ack   = '0;
        io_bus.m_err   = '0;
        io_bus.m_dat_r = '0;
        if (w_granted) begin
            io_bus.s_we    = io_bus.m_we[w_own];
            io_bus.s_adr   = w_adr;
            io_bus.s_dat_w = io_bus.m_dat_w[w_own];
            io_bus.s_sel   = io_bus.m_sel[w_own];
            if (w_any_hit) begin
                io_bus.s_cyc[w_hit] = w_cyc;
                io_bus.s_stb[w_hit] = w_stb & ~r_err_q;
            end
            io_bus.m_ack[w_own] = w_ack;
            io_bus.m_err[w_own] = r_err_q;
            if (w_ack) begin
                io_bus.m_dat_r[w_own] = io_bus.s_dat_r[w_hit];
            end
        end
    end

    assign io_bus.gnt = r_gnt;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= S_IDLE;
            r_last  <= 1'b1;
            r_gnt   <= 2'b00;
            r_cnt   <= '0;
            r_err_q <= 1'b0;
        end else begin
            r_err_q <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (io_bus.m_cyc[0] && (!io_bus.m_cyc[1] || r_last)) begin
                        r_state <= S_GNT0;
                        r_gnt   <= 2'b01;
                    end else if (io_bus.m_cyc[1]) begin
                        r_state <= S_GNT1;
                        r_gnt   <= 2'b10;
                    end
                end
                S_GNT0, S_GNT1: begin
                    if (!io_bus.m_cyc[w_own]) begin
                        r_state <= S_IDLE;
                        r_gnt   <= 2'b00;
                        r_last  <= w_own;
                        r_cnt   <= '0;
                    end else if (w_stb && !w_any_hit && !r_err_q) begin
                        r_err_q <= 1'b1;
                        r_cnt   <= '0;
                    end else if (w_stall) begin
                        if (r_cnt == LP_TO) begin
                            r_err_q <= 1'b1;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end else begin
                        r_cnt <= '0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_gnt   <= 2'b00;
                    r_cnt   <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_wb_shared_bus.sv
// Self-checking bench for wb_shared_bus: directed scenarios plus randomized single transfers
// checked against an address-range reference model.
module tb_wb_shared_bus;
    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int NSLV    = 3;
    localparam int TIMEOUT = 255;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    wb_shared_bus_if #(.AW(AW), .DW(DW), .NSLV(NSLV)) bus_if ();

    wb_shared_bus #(.AW(AW), .DW(DW), .NSLV(NSLV), .TIMEOUT(TIMEOUT)) dut (
        .i_clock   (clk),
        .i_reset_n (rst_n),
        .io_bus    (bus_if.bus)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    // Memory map as address ranges: bootRom 4 KiB @0, ram 64 KiB @0x1000_0000, led 16 B @0x8000_0000.
    function automatic int ref_slave(input logic [31:0] a);
        if (a < 32'h0000_1000) return 0;
        if (a >= 32'h1000_0000 && a < 32'h1001_0000) return 1;
        if (a >= 32'h8000_0000 && a < 32'h8000_0010) return 2;
        return -1;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus_if.m_cyc   = '0;
        bus_if.m_stb   = '0;
        bus_if.m_we    = '0;
        bus_if.m_adr   = '0;
        bus_if.m_dat_w = '0;
        bus_if.m_sel   = '0;
        bus_if.s_dat_r = '0;
        bus_if.s_ack   = '0;
    endtask

    task automatic release_bus();
        drive_idle();
        next_cycle();
    endtask

    task automatic do_reset();
        drive_idle();
        rst_n = 1'b0;
        #7;
        rst_n = 1'b1;
        next_cycle();
    endtask

    task automatic request(input int mi, input logic we, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] sel);
        bus_if.m_cyc[mi]   = 1'b1;
        bus_if.m_stb[mi]   = 1'b1;
        bus_if.m_we[mi]    = we;
        bus_if.m_adr[mi]   = a;
        bus_if.m_dat_w[mi] = d;
        bus_if.m_sel[mi]   = sel;
    endtask

    task automatic test_reset();
        drive_idle();
        rst_n = 1'b0;
        #3;
        n_tests++;
        if (bus_if.gnt !== 2'b00) begin
            n_fail++; $display("FAIL reset_gnt: got %b, expected 00", bus_if.gnt);
        end
        n_tests++;
        if (bus_if.s_cyc !== 3'b000 || bus_if.s_stb !== 3'b000) begin
            n_fail++; $display("FAIL reset_s_cyc_stb: got %b/%b, expected 000/000", bus_if.s_cyc, bus_if.s_stb);
        end
        n_tests++;
        if (bus_if.m_ack !== 2'b00 || bus_if.m_err !== 2'b00 || bus_if.m_dat_r !== '0) begin
            n_fail++; $display("FAIL reset_m_ret: got ack %b err %b, expected 00/00", bus_if.m_ack, bus_if.m_err);
        end
        rst_n = 1'b1;
        next_cycle();
        n_tests++;
        if (bus_if.gnt !== 2'b00) begin
            n_fail++; $display("FAIL reset_idle_gnt: got %b, expected 00", bus_if.gnt);
        end
    endtask

    task automatic test_contention();
        do_reset();
        bus_if.m_cyc = 2'b11;
        #1;
        n_tests++;
        if (bus_if.gnt !== 2'b00) begin
            n_fail++; $display("FAIL cont_t0: got %b, expected 00", bus_if.gnt);
        end
        next_cycle();
        n_tests++;
        if (bus_if.gnt !== 2'b01) begin
            n_fail++; $display("FAIL cont_t1: got %b, expected 01", bus_if.gnt);
        end
        next_cycle();
        n_tests++;
        if (bus_if.gnt !== 2'b01) begin
            n_fail++; $display("FAIL cont_t2_nopreempt: got %b, expected 01", bus_if.gnt);
        end
        next_cycle();
        bus_if.m_cyc[0] = 1'b0;
        #1;
        n_tests++;
        if (bus_if.gnt !== 2'b01) begin
            n_fail++; $display("FAIL cont_t3: got %b, expected 01", bus_if.gnt);
        end
        next_cycle();
        n_tests++;
        if (bus_if.gnt !== 2'b00) begin
            n_fail++; $display("FAIL cont_t4_idle_gap: got %b, expected 00", bus_if.gnt);
        end
        next_cycle();
        n_tests++;
        if (bus_if.gnt !== 2'b10) begin
            n_fail++; $display("FAIL cont_t5: got %b, expected 10", bus_if.gnt);
        end
        release_bus();
    endtask

    task automatic test_decode_write();
        request(1, 1'b1, 32'h1000_0010, 32'hDEAD_BEEF, 4'hF);
        next_cycle();
        n_tests++;
        if (bus_if.s_stb !== 3'b010 || bus_if.s_cyc !== 3'b010) begin
            n_fail++; $display("FAIL wr_decode: got stb %b cyc %b, expected 010/010", bus_if.s_stb, bus_if.s_cyc);
        end
        n_tests++;
        if (bus_if.s_dat_w !== 32'hDEAD_BEEF || bus_if.s_we !== 1'b1 || bus_if.s_sel !== 4'hF
            || bus_if.s_adr !== 32'h1000_0010) begin
            n_fail++; $display("FAIL wr_fwd: got dat %h we %b sel %h adr %h, expected DEADBEEF 1 F 10000010",
                               bus_if.s_dat_w, bus_if.s_we, bus_if.s_sel, bus_if.s_adr);
        end
        n_tests++;
        if (bus_if.m_ack !== 2'b00) begin
            n_fail++; $display("FAIL wr_noack_yet: got %b, expected 00", bus_if.m_ack);
        end
        bus_if.s_ack[1] = 1'b1;
        #1;
        n_tests++;
        if (bus_if.m_ack !== 2'b10 || bus_if.m_err !== 2'b00) begin
            n_fail++; $display("FAIL wr_ack: got ack %b err %b, expected 10/00", bus_if.m_ack, bus_if.m_err);
        end
        next_cycle();
        release_bus();
    endtask

    task automatic test_read_led();
        request(1, 1'b0, 32'h8000_0004, 32'h0, 4'hF);
        next_cycle();
        n_tests++;
        if (bus_if.s_stb !== 3'b100 || bus_if.m_dat_r[1] !== 32'h0) begin
            n_fail++; $display("FAIL rd_led_stb: got stb %b dat %h, expected 100/0", bus_if.s_stb, bus_if.m_dat_r[1]);
        end
        bus_if.s_dat_r[0] = 32'hBAD0_0000;
        bus_if.s_dat_r[2] = 32'h0000_0005;
        bus_if.s_ack[2]   = 1'b1;
        #1;
        n_tests++;
        if (bus_if.m_ack !== 2'b10 || bus_if.m_dat_r[1] !== 32'h5 || bus_if.s_stb[0] !== 1'b0) begin
            n_fail++; $display("FAIL rd_led_data: got ack %b dat %h stb0 %b, expected 10 5 0",
                               bus_if.m_ack, bus_if.m_dat_r[1], bus_if.s_stb[0]);
        end
        next_cycle();
        release_bus();
    endtask

    task automatic test_unmapped();
        request(0, 1'b0, 32'h4000_0000, 32'h0, 4'hF);
        next_cycle();
        n_tests++;
        if (bus_if.gnt !== 2'b01 || bus_if.s_stb !== 3'b000 || bus_if.s_cyc !== 3'b000 || bus_if.m_err !== 2'b00) begin
            n_fail++; $display("FAIL unm_c1: got gnt %b stb %b cyc %b err %b, expected 01 000 000 00",
                               bus_if.gnt, bus_if.s_stb, bus_if.s_cyc, bus_if.m_err);
        end
        next_cycle();
        n_tests++;
        if (bus_if.m_err !== 2'b01 || bus_if.m_ack !== 2'b00) begin
            n_fail++; $display("FAIL unm_err: got err %b ack %b, expected 01/00", bus_if.m_err, bus_if.m_ack);
        end
        next_cycle();
        n_tests++;
        if (bus_if.m_err !== 2'b00) begin
            n_fail++; $display("FAIL unm_pulse_len: got %b, expected 00", bus_if.m_err);
        end
        next_cycle();
        n_tests++;
        if (bus_if.m_err !== 2'b01) begin
            n_fail++; $display("FAIL unm_retrigger: got %b, expected 01", bus_if.m_err);
        end
        release_bus();
    endtask

    task automatic test_back_to_back();
        logic [31:0] adrs [3];
        logic [31:0] rd;
        int          exp;
        adrs[0] = 32'h0000_0100;
        adrs[1] = 32'h1000_0004;
        adrs[2] = 32'h8000_0008;
        request(0, 1'b0, adrs[0], 32'h0, 4'hF);
        next_cycle();
        for (int k = 0; k < 3; k++) begin
            exp = ref_slave(adrs[k]);
            rd  = $urandom;
            bus_if.m_adr[0]     = adrs[k];
            bus_if.s_ack        = '0;
            bus_if.s_ack[exp]   = 1'b1;
            bus_if.s_dat_r[exp] = rd;
            #1;
            n_tests++;
            if (bus_if.s_stb !== 3'(1 << exp) || bus_if.m_ack !== 2'b01 || bus_if.m_dat_r[0] !== rd) begin
                n_fail++; $display("FAIL b2b_%0d: got stb %b ack %b dat %h, expected %b 01 %h",
                                   k, bus_if.s_stb, bus_if.m_ack, bus_if.m_dat_r[0], 3'(1 << exp), rd);
            end
            next_cycle();
        end
        release_bus();
    endtask

    task automatic test_timeout();
        int          err_at;
        int          i;
        int          early_err;
        logic [31:0] rd;
        request(0, 1'b0, 32'h1000_0100, 32'h0, 4'hF);
        next_cycle();
        // Stalled cycles 0..TIMEOUT fill the counter, one more to compare, pulse the cycle after.
        err_at = -1;
        i = 0;
        while (err_at < 0 && i <= TIMEOUT + 8) begin
            if (bus_if.m_err[0] === 1'b1) err_at = i;
            else begin
                next_cycle();
                i++;
            end
        end
        n_tests++;
        if (err_at !== TIMEOUT + 1) begin
            n_fail++; $display("FAIL to_latency: got err at cycle %0d, expected %0d", err_at, TIMEOUT + 1);
        end
        bus_if.s_ack[1] = 1'b1;
        #1;
        n_tests++;
        if (bus_if.s_stb !== 3'b000 || bus_if.m_ack !== 2'b00 || bus_if.m_err !== 2'b01) begin
            n_fail++; $display("FAIL to_err_cycle: got stb %b ack %b err %b, expected 000 00 01",
                               bus_if.s_stb, bus_if.m_ack, bus_if.m_err);
        end
        bus_if.s_ack[1] = 1'b0;
        next_cycle();
        n_tests++;
        if (bus_if.m_err !== 2'b00 || bus_if.s_stb !== 3'b010) begin
            n_fail++; $display("FAIL to_after_pulse: got err %b stb %b, expected 00 010", bus_if.m_err, bus_if.s_stb);
        end
        early_err = 0;
        for (int c = 0; c < 250; c++) begin
            next_cycle();
            if (bus_if.m_err !== 2'b00) early_err++;
        end
        n_tests++;
        if (early_err !== 0) begin
            n_fail++; $display("FAIL to_cnt_cleared: got %0d err cycles, expected 0", early_err);
        end
        rd = $urandom;
        bus_if.s_dat_r[1] = rd;
        bus_if.s_ack[1]   = 1'b1;
        #1;
        n_tests++;
        if (bus_if.m_ack !== 2'b01 || bus_if.m_dat_r[0] !== rd) begin
            n_fail++; $display("FAIL to_next_ok: got ack %b dat %h, expected 01 %h", bus_if.m_ack, bus_if.m_dat_r[0], rd);
        end
        next_cycle();
        release_bus();
    endtask

    task automatic test_reset_mid();
        request(1, 1'b0, 32'h1000_0020, 32'h0, 4'hF);
        next_cycle();
        bus_if.s_ack[1] = 1'b1;
        #1;
        n_tests++;
        if (bus_if.m_ack !== 2'b10) begin
            n_fail++; $display("FAIL rstmid_pre: got %b, expected 10", bus_if.m_ack);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (bus_if.gnt !== 2'b00 || bus_if.s_cyc !== 3'b000 || bus_if.m_ack !== 2'b00) begin
            n_fail++; $display("FAIL rstmid: got gnt %b cyc %b ack %b, expected 00 000 00",
                               bus_if.gnt, bus_if.s_cyc, bus_if.m_ack);
        end
        rst_n = 1'b1;
        drive_idle();
        next_cycle();
    endtask

    task automatic test_random();
        logic [31:0] unm [4];
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd [3];
        logic [3:0]  sel;
        logic        we;
        int          mi;
        int          r;
        int          exp;
        int          lat;
        int          stall_bad;
        logic [2:0]  exp_stb;
        unm[0] = 32'h4000_0000;
        unm[1] = 32'h0000_1000;
        unm[2] = 32'h8000_0010;
        unm[3] = 32'h1001_0000;
        for (int t = 0; t < 40; t++) begin
            mi  = $urandom_range(0, 1);
            r   = $urandom_range(0, 3);
            lat = $urandom_range(0, 3);
            we  = 1'($urandom_range(0, 1));
            wd  = $urandom;
            sel = 4'($urandom);
            case (r)
                0:       a = $urandom & 32'h0000_0FFC;
                1:       a = 32'h1000_0000 | ($urandom & 32'h0000_FFFC);
                2:       a = 32'h8000_0000 | ($urandom & 32'h0000_000C);
                default: a = unm[$urandom_range(0, 3)];
            endcase
            exp     = ref_slave(a);
            exp_stb = (exp < 0) ? 3'b000 : 3'(1 << exp);
            request(mi, we, a, wd, sel);
            next_cycle();
            n_tests++;
            if (bus_if.gnt !== 2'(1 << mi) || bus_if.s_stb !== exp_stb || bus_if.s_cyc !== exp_stb) begin
                n_fail++; $display("FAIL rand_route t=%0d: got gnt %b stb %b cyc %b, expected %b %b %b",
                                   t, bus_if.gnt, bus_if.s_stb, bus_if.s_cyc, 2'(1 << mi), exp_stb, exp_stb);
            end
            n_tests++;
            if (bus_if.s_adr !== a || bus_if.s_dat_w !== wd || bus_if.s_we !== we || bus_if.s_sel !== sel) begin
                n_fail++; $display("FAIL rand_fwd t=%0d: got adr %h dat %h we %b sel %h, expected %h %h %b %h",
                                   t, bus_if.s_adr, bus_if.s_dat_w, bus_if.s_we, bus_if.s_sel, a, wd, we, sel);
            end
            if (exp < 0) begin
                next_cycle();
                n_tests++;
                if (bus_if.m_err !== 2'(1 << mi) || bus_if.m_ack !== 2'b00) begin
                    n_fail++; $display("FAIL rand_unm t=%0d: got err %b ack %b, expected %b 00",
                                       t, bus_if.m_err, bus_if.m_ack, 2'(1 << mi));
                end
            end else begin
                stall_bad = 0;
                for (int c = 0; c < lat; c++) begin
                    if (bus_if.m_ack !== 2'b00 || bus_if.m_err !== 2'b00) stall_bad++;
                    next_cycle();
                end
                for (int s = 0; s < 3; s++) begin
                    rd[s] = $urandom;
                    bus_if.s_dat_r[s] = rd[s];
                end
                bus_if.s_ack[exp] = 1'b1;
                #1;
                n_tests++;
                if (stall_bad !== 0 || bus_if.m_ack !== 2'(1 << mi) || bus_if.m_dat_r[mi] !== rd[exp]
                    || bus_if.m_dat_r[1-mi] !== 32'h0) begin
                    n_fail++; $display("FAIL rand_ack t=%0d: got stall_bad %0d ack %b dat %h, expected 0 %b %h",
                                       t, stall_bad, bus_if.m_ack, bus_if.m_dat_r[mi], 2'(1 << mi), rd[exp]);
                end
                next_cycle();
            end
            release_bus();
        end
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_contention();
        test_decode_write();
        test_read_led();
        test_unmapped();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
